camera_capture_win: RTL
=======================

// Module: camera_capture_win
// PURPOSE
//   Parametrised OV7670-style DVP capture front end; successor to the fixed 2-byte/pixel reader.
//   Assembles 1- or 2-byte pixels from the 8-bit bus and decimates by DECIM in X and Y.
//   Emits one write (data+address) per stored pixel to the frame buffer, plus frame status.
//   Checks line and frame geometry and keeps a frame counter. Sits between camera pins and frame RAM.
// PARAMETERS
//   BPP      2    bytes per pixel (1 or 2); first byte on the bus is the MSB
//   FRAME_W  640  expected pixels per href line
//   FRAME_H  480  expected href lines per frame
//   DECIM    1    keep pixel when x%DECIM==0 and y%DECIM==0 (1, 2 or 4)
//   ADDR_W   17   width of the write address
// PORTS
//   p_clock      in   1         camera pixel clock; all logic on its rising edge
//   reset_n      in   1         asynchronous, active-low reset
//   enable       in   1         capture enable, sampled only at frame start
//   vsync        in   1         frame sync, high = vertical blanking
//   href         in   1         line valid, high = bytes on p_data are valid
//   p_data       in   8         camera byte bus
//   pixel_data   out  8*BPP     assembled pixel
//   pixel_valid  out  1         1-cycle write strobe for pixel_data/address
//   address      out  ADDR_W    write address of pixel_data; first stored pixel = 0
//   frame_done   out  1         1-cycle pulse at the end of a captured frame
//   frame_error  out  1         geometry status of last frame; updated with frame_done
//   frame_count  out  8         count of completed frames, wraps 255->0
// BEHAVIOUR
//   Reset: all outputs 0; state SYNC; counters and byte phase 0. Mid-frame reset discards the frame.
//   FSM:
//     SYNC: wait for vsync=1 (never start mid-frame) -> ARM.
//     ARM: on vsync=0: enable=1 -> CAPTURE, clear x, y, address, byte phase, err_sticky;
//       enable=0 -> SYNC.
//     CAPTURE: on vsync=1 -> SYNC, frame_done=1 for one cycle,
//       frame_error = err_sticky | (y != FRAME_H), frame_count++. Deasserting enable has no effect here.
//   Byte assembly (CAPTURE, href=1): byte phase counts 0..BPP-1; byte k goes to
//     pixel_data[8*(BPP-k)-1 -: 8]. On the last byte, x++ and phase returns to 0.
//   Phase is forced to 0 on every href rising edge. A partial pixel at href fall is dropped.
//   Store rule: the last byte of pixel (x,y) with x%DECIM==0 and y%DECIM==0 is sampled at edge N.
//     At edge N: pixel_data updated and pixel_valid=1 through cycle N+1, with address = current count.
//     At edge N+1: address increments, wrapping at 2^ADDR_W.
//     Otherwise pixel_valid=0.
//   Line end (href 1->0 in CAPTURE): if x != FRAME_W, set err_sticky.
//     Then x <= 0 and y++; y saturates at 2^16-1.
//   vsync rising during href=1: frame ends; an incomplete line sets err_sticky via the y check.
//   frame_error holds its value until the next frame_done. frame_count wraps modulo 256.
//   x/y: 16-bit internal counters; the DECIM test uses the low bits (DECIM a power of 2).
// TESTING
//   1. BPP=2, DECIM=1, FRAME 4x2, bytes 0x12,0x34,...
//      -> 8 strobes, first pixel 0x1234 @addr 0, last @addr 7; frame_done with frame_error=0; frame_count=1.
//   2. BPP=1, DECIM=2, FRAME 8x4 -> 8 strobes, addresses 0..7, pixels from even x of rows 0 and 2 only.
//   3. Line with 3 pixels when FRAME_W=4 -> frame_error=1 at frame_done;
//      next clean frame -> frame_error=0.
//   4. reset_n low mid-line -> outputs 0 immediately.
//      After release, no strobes until a full vsync high->low; next frame starts at addr 0.
//   5. enable=0 at ARM -> no strobes, no frame_done.
//      enable dropped mid-frame -> frame completes, frame_count++.
//   6. Odd byte count on a line with BPP=2 -> last byte dropped;
//      next line's first pixel is assembled MSB-first, correctly aligned.

Source files
------------

// File: rtl/camera_capture_win_if.sv
// camera_capture_win_if
//   Bundles the DVP camera pins and the frame-buffer write/status signals
//   of camera_capture_win.
//   Camera side : enable, vsync, href, p_data
//   Buffer side : pixel_data, pixel_valid, address
//   Status side : frame_done, frame_error, frame_count
//   Modports    : slave  = the capture block
//                 master = the camera/frame-buffer environment
interface camera_capture_win_if #(
  parameter int BPP    = 2,
  parameter int ADDR_W = 17
);
  logic                enable;
  logic                vsync;
  logic                href;
  logic [7:0]          p_data;
  logic [8*BPP-1:0]    pixel_data;
  logic                pixel_valid;
  logic [ADDR_W-1:0]   address;
  logic                frame_done;
  logic                frame_error;
  logic [7:0]          frame_count;

  modport slave (
    input  enable, vsync, href, p_data,
    output pixel_data, pixel_valid, address, frame_done, frame_error, frame_count
  );

  modport master (
    output enable, vsync, href, p_data,
    input  pixel_data, pixel_valid, address, frame_done, frame_error, frame_count
  );
endinterface

// File: rtl/camera_capture_win.sv
// camera_capture_win
//   DVP camera capture front end. Assembles BPP-byte pixels (first byte is
//   the MSB), decimates by DECIM in X and Y, emits one frame-buffer write per
//   stored pixel and reports per-frame geometry status and a frame counter.
//   p_clock : pixel clock, all logic on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : camera pins in, pixel write strobe/data/address and frame
//             status out (see camera_capture_win_if)
module camera_capture_win #(
  parameter int BPP     = 2,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int DECIM   = 1,
  parameter int ADDR_W  = 17
) (
  input  logic                 p_clock,
  input  logic                 reset_n,
  camera_capture_win_if.slave  bus
);

  localparam int                PH_W    = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(BPP - 1);
  localparam logic [15:0]       DMASK   = 16'(DECIM - 1);

  typedef enum logic [1:0] {SYNC, ARM, CAPTURE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_start;
  logic              w_frame_end;

  logic              r_href_d;
  logic [PH_W-1:0]   r_phase;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [8*BPP-1:0]  r_asm;
  logic [8*BPP-1:0]  r_pixel_data;
  logic              r_pixel_valid;
  logic              r_frame_done;
  logic              r_frame_error;
  logic [7:0]        r_frame_count;

  logic              w_active;
  logic              w_href_rise;
  logic              w_href_fall;
  logic [PH_W-1:0]   w_phase;
  logic              w_keep;
  logic [8*BPP-1:0]  w_asm;

  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) r_state <= SYNC;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_frame_end  = 1'b0;
    unique case (r_state)
      SYNC:    if (bus.vsync) w_state_next = ARM;
      ARM: begin
        if (!bus.vsync) begin
          if (bus.enable) begin
            w_state_next = CAPTURE;
            w_start      = 1'b1;
          end else begin
            w_state_next = SYNC;
          end
        end
      end
      CAPTURE: begin
        if (bus.vsync) begin
          w_state_next = SYNC;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = SYNC;
    endcase
  end

  // Bytes are only consumed while capturing outside vertical blanking, so a
  // vsync rise during href ends the frame without a line end (short y).
  assign w_active    = (r_state == CAPTURE) && !bus.vsync;
  assign w_href_rise = bus.href && !r_href_d;
  assign w_href_fall = !bus.href && r_href_d;
  assign w_phase     = w_href_rise ? '0 : r_phase;
  assign w_keep      = ((r_x & DMASK) == '0) && ((r_y & DMASK) == '0);

  // Current byte merged into the partial pixel at its MSB-first position.
  always_comb begin
    w_asm = r_asm;
    for (int unsigned k = 0; k < BPP; k++) begin
      if (w_phase == PH_W'(k)) w_asm[8*(BPP-k)-1 -: 8] = bus.p_data;
    end
  end

  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_href_d      <= 1'b0;
      r_phase       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_err         <= 1'b0;
      r_asm         <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_href_d      <= bus.href;
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      // Address advances the cycle after the strobe so the strobe cycle
      // presents the address of the pixel being written.
      if (r_pixel_valid) r_addr <= r_addr + 1'b1;
      if (w_start) begin
        r_x     <= '0;
        r_y     <= '0;
        r_addr  <= '0;
        r_phase <= '0;
        r_err   <= 1'b0;
      end else if (w_frame_end) begin
        r_frame_done  <= 1'b1;
        r_frame_error <= r_err | (r_y != 16'(FRAME_H));
        r_frame_count <= r_frame_count + 8'd1;
      end else if (w_active) begin
        if (bus.href) begin
          r_asm <= w_asm;
          if (w_phase == PH_LAST) begin
            r_phase <= '0;
            r_x     <= r_x + 16'd1;
            if (w_keep) begin
              r_pixel_data  <= w_asm;
              r_pixel_valid <= 1'b1;
            end
          end else begin
            r_phase <= w_phase + 1'b1;
          end
        end else if (w_href_fall) begin
          if (r_x != 16'(FRAME_W)) r_err <= 1'b1;
          r_x     <= '0;
          r_phase <= '0;
          if (r_y != '1) r_y <= r_y + 16'd1;
        end
      end
    end
  end

  assign bus.pixel_data  = r_pixel_data;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.address     = r_addr;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_error = r_frame_error;
  assign bus.frame_count = r_frame_count;

endmodule
